mod_mul_operand_pipe: RTL

//  Pipelined k-bit x k-bit multiplier stage directly upstream of the Barrett reduction block.

---
 rtl/mod_mul_operand_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mod_mul_operand_pipe.sv
// -----------------------------------------------------------------------------
// mod_mul_operand_pipe
//   Pipelined K x K unsigned multiplier that feeds the Barrett reducer. It takes
//   coefficient pairs (a, b) on a valid/ready stream and emits the full 2K-bit
//   product, together with the coefficient index within the polynomial and an
//   end-of-polynomial flag. The whole pipe advances on one global enable, so
//   back-pressure freezes every stage at once and bubbles are preserved.
//
// Parameters
//   Q      modulus shared with the downstream reducer
//   LAT    pipeline depth, accept to out_valid, 1..8
//   N      coefficients per polynomial, power of two
//   K      operand width, $clog2(Q)   (derived)
//   IDX_W  index width, $clog2(N)     (derived)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready depends only on the output side
//   in_a, in_b [K]         operands, expected < Q
//   out_valid/out_ready    output handshake
//   out_prod [2K]          in_a * in_b, exact
//   out_idx [IDX_W]        index of this beat within the polynomial
//   out_last               beat carries index N-1
//   out_err                operand range error on this beat
//   err_sticky             some errored beat has left the pipe since reset
//
// Configuration
//   MODMUL_RANGE_CHECK_EN  defined: flag beats with in_a >= Q or in_b >= Q and
//                          keep a sticky error; undefined: no comparators,
//                          out_err and err_sticky are constant 0.
// -----------------------------------------------------------------------------
module mod_mul_operand_pipe #(
  parameter  int Q     = 12289,
  parameter  int LAT   = 3,
  parameter  int N     = 1024,
  localparam int K     = $clog2(Q),
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_a,
  input  logic [K-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*K-1:0]   out_prod,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err,
  output logic             err_sticky
);

  logic             w_adv;
  logic             w_accept;
  logic [2*K-1:0]   w_prod;

  logic [LAT-1:0]   r_vld;
  logic [2*K-1:0]   r_prod [LAT];
  logic [IDX_W-1:0] r_idx  [LAT];
  logic [IDX_W-1:0] r_cnt;

  // The pipe moves whenever the last slot is empty or being taken; in_ready
  // is exactly that enable and never looks at in_valid.
  assign w_adv    = out_ready || !r_vld[LAT-1];
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;

  // Operands are widened first so the product is the exact 2K-bit value.
  assign w_prod = (2*K)'(in_a) * (2*K)'(in_b);

  // NOTE: data slots are reset too, not just the valid bits, so that out_prod
  // and out_idx are defined (never X) on invalid slots after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_prod[i] <= '0;
        r_idx[i]  <= '0;
      end
    end else if (w_adv) begin
      // NOTE: non-blocking assignments make every stage read the value its
      // predecessor held before this edge, so the loop order is irrelevant.
      r_vld[0]  <= in_valid;
      r_prod[0] <= w_prod;
      r_idx[0]  <= r_cnt;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_prod[i] <= r_prod[i-1];
        r_idx[i]  <= r_idx[i-1];
      end
    end
  end

  // Coefficient index; N is a power of two, so natural overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign out_prod  = r_prod[LAT-1];
  assign out_idx   = r_idx[LAT-1];
  assign out_last  = (r_idx[LAT-1] == IDX_W'(N - 1));

`ifdef MODMUL_RANGE_CHECK_EN
  // One extra bit so the comparison stays correct when Q is a power of two.
  localparam logic [K:0] QV = (K+1)'(Q);

  logic           w_err;
  logic [LAT-1:0] r_err;
  logic           r_sticky;

  assign w_err = ({1'b0, in_a} >= QV) || ({1'b0, in_b} >= QV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_adv) begin
      r_err[0] <= w_err;
      for (int i = 1; i < LAT; i++) begin
        r_err[i] <= r_err[i-1];
      end
    end
  end

  // Sticky only counts errored beats that actually transfer out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_vld[LAT-1] && out_ready && r_err[LAT-1]) begin
      r_sticky <= 1'b1;
    end
  end

  assign out_err    = r_err[LAT-1];
  assign err_sticky = r_sticky;
`else
  assign out_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule
